// File: rtl/cgra_context_loader.sv
`default_nettype none
// cgra_context_loader: streams host context words onto the broadcast PE data bus with one-hot strobes, then raises array start.
// Optional feature macro CTX_PARITY_EN: drop words failing even parity over {cfg_data, cfg_par}.
module cgra_context_loader #(
   parameter int WIDTH     = 120,
   parameter int NUM_PE    = 16,
   parameter int CTX_DEPTH = 16,
   parameter int PE_W      = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [WIDTH:0]    cfg_data,
   input  logic [PE_W-1:0]   cfg_pe,
   input  logic              cfg_last,
   input  logic              cfg_par,
   input  logic              run_req,
   input  logic              stop_req,
   output logic [WIDTH:0]    pe_data,
   output logic [NUM_PE-1:0] pe_wr,
   output logic              pe_start,
   output logic              busy,
   output logic              err
);

   localparam int CW = $clog2(CTX_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ARM  = 2'd2,
      RUN  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [CW-1:0]     wcnt;
   logic              accept;
   logic              full;
   logic              pe_ok;
   logic              par_ok;
   logic              keep;
   logic [NUM_PE-1:0] onehot;

   // Ready is forced low while reset is asserted, not just after the first edge.
   assign cfg_ready = RST_N && ((state == IDLE) || (state == LOAD));
   assign accept    = cfg_valid && cfg_ready;
   assign full      = (wcnt == CW'(CTX_DEPTH));
   assign pe_ok     = (32'(cfg_pe) < NUM_PE);

`ifdef CTX_PARITY_EN
   assign par_ok = ~(^{cfg_data, cfg_par});
`else
   logic unused_par;
   assign unused_par = cfg_par;
   assign par_ok     = 1'b1;
`endif

   assign keep = accept && !full && pe_ok && par_ok;

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         onehot[i] = (32'(cfg_pe) == i);
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (run_req)                   state_nx = ARM;
            else if (accept && !cfg_last)  state_nx = LOAD;
         end
         LOAD: begin
            if (run_req)                   state_nx = ARM;
            else if (accept && cfg_last)   state_nx = IDLE;
         end
         ARM:     state_nx = RUN;
         RUN: begin
            if (stop_req)                  state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Start and busy are registered from the next state so they track the state register exactly.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         wcnt     <= '0;
         pe_data  <= '0;
         pe_wr    <= '0;
         pe_start <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nx;
         pe_start <= (state_nx == RUN);
         busy     <= (state_nx == ARM) || (state_nx == RUN);
         pe_wr    <= keep ? onehot : '0;
         if (accept) begin
            pe_data <= cfg_data;
            if (cfg_last)   wcnt <= '0;
            else if (!full) wcnt <= wcnt + CW'(1);
            if (!keep)      err  <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
